// File: rtl/hf_pkg.sv
// Shared command codes, mode codes and FSM encoding for the HF configuration
// receiver and its SPI front end.
package hf_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
    localparam logic [3:0] CMD_WRITE_REG   = 4'b0010;
    localparam logic [3:0] CMD_READ_REG    = 4'b0011;

    localparam logic [2:0] MODE_0   = 3'd0;
    localparam logic [2:0] MODE_1   = 3'd1;
    localparam logic [2:0] MODE_2   = 3'd2;
    localparam logic [2:0] MODE_3   = 3'd3;
    localparam logic [2:0] MODE_4   = 3'd4;
    localparam logic [2:0] MODE_OFF = 3'd7;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_QUIET = 1'b1
    } mode_state_e;

endpackage

// File: rtl/spi_oversample_rx.sv
// Oversampled SPI slave: synchronises spck/mosi/ncs into the system clock,
// shifts in one frame per ncs window and shifts read-back data out on miso.
module spi_oversample_rx
    import hf_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  spck_i,
    input  logic                  mosi_i,
    input  logic                  ncs_i,
    input  logic [FRAME_BITS-1:0] rd_buf_i,
    output logic                  miso_o,
    output logic                  frame_valid_o,
    output logic                  frame_bad_o,
    output logic [FRAME_BITS-1:0] frame_word_o
);

    logic spck_s1_q, spck_s2_q, spck_d1_q;
    logic mosi_s1_q, mosi_s2_q;
    logic ncs_s1_q, ncs_s2_q, ncs_d1_q;

    logic [1:0]            warm_q, warm_d;
    logic                  armed_q, armed_d;
    logic                  active_q, active_d;
    logic [4:0]            bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;

    logic spck_rise, spck_fall, ncs_rise, ncs_fall;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            spck_s1_q <= 1'b0;
            spck_s2_q <= 1'b0;
            spck_d1_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            ncs_s1_q  <= 1'b1;
            ncs_s2_q  <= 1'b1;
            ncs_d1_q  <= 1'b1;
        end else begin
            spck_s1_q <= spck_i;
            spck_s2_q <= spck_s1_q;
            spck_d1_q <= spck_s2_q;
            mosi_s1_q <= mosi_i;
            mosi_s2_q <= mosi_s1_q;
            ncs_s1_q  <= ncs_i;
            ncs_s2_q  <= ncs_s1_q;
            ncs_d1_q  <= ncs_s2_q;
        end
    end

    assign spck_rise = spck_s2_q & ~spck_d1_q;
    assign spck_fall = ~spck_s2_q & spck_d1_q;
    assign ncs_rise  = ncs_s2_q & ~ncs_d1_q;
    assign ncs_fall  = ~ncs_s2_q & ncs_d1_q;

    // A frame only starts after ncs has really been seen high once the
    // synchronisers hold pin data, so a frame cut by reset is never decoded.
    always_comb begin
        warm_d   = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        armed_d  = armed_q | ((warm_q == 2'd2) & ncs_s2_q);
        active_d = active_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (ncs_fall && armed_q) begin
            active_d = 1'b1;
            bitcnt_d = 5'd0;
            tx_d     = rd_buf_i;
        end else if (!ncs_s2_q) begin
            if (spck_rise) begin
                shift_d = {shift_q[FRAME_BITS-2:0], mosi_s2_q};
                if (bitcnt_q != 5'd31) bitcnt_d = bitcnt_q + 5'd1;
            end
            if (spck_fall) tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
        if (ncs_rise) active_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            warm_q   <= 2'd0;
            armed_q  <= 1'b0;
            active_q <= 1'b0;
            bitcnt_q <= 5'd0;
            shift_q  <= '0;
            tx_q     <= '0;
        end else begin
            warm_q   <= warm_d;
            armed_q  <= armed_d;
            active_q <= active_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign miso_o        = ~ncs_s2_q & tx_q[FRAME_BITS-1];
    assign frame_valid_o = ncs_rise & active_q & (bitcnt_q == 5'(FRAME_BITS));
    assign frame_bad_o   = ncs_rise & active_q & (bitcnt_q != 5'(FRAME_BITS));
    assign frame_word_o  = shift_q;

endmodule

// File: rtl/hf_conf_ctrl.sv
// HF configuration receiver: decodes SPI command frames into a register file
// with read-back, and gates major-mode changes through an OFF guard interval.
module hf_conf_ctrl
    import hf_pkg::*;
#(
    parameter int          NUM_REGS     = 4,
    parameter int          MODE_BITS    = 3,
    parameter int unsigned OFF_MODE     = 7,
    parameter int          GUARD_CYCLES = 16,
    parameter logic [7:0]  CONF_RESET   = 8'hE0
) (
    input  logic                  ck_1356meg,
    input  logic                  nrst,
    input  logic                  spck,
    input  logic                  mosi,
    input  logic                  ncs,
    output logic                  miso,
    output logic [7:0]            conf_word,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic [MODE_BITS-1:0]  major_mode,
    output logic                  mode_switching,
    output logic [7:0]            frame_err_cnt
);

    localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [MODE_BITS-1:0] OFF_CODE = MODE_BITS'(OFF_MODE);

    logic                  frame_valid, frame_bad;
    logic [FRAME_BITS-1:0] frame_word;
    logic [3:0]            cmd, addr;
    logic [7:0]            data, rd_data;
    logic                  addr_ok, err_bump;

    logic [7:0]            regs_q [NUM_REGS];
    logic [7:0]            regs_d [NUM_REGS];
    logic [FRAME_BITS-1:0] rd_buf_q, rd_buf_d;
    logic [7:0]            err_q, err_d;

    mode_state_e           state_q, state_d;
    logic [MODE_BITS-1:0]  mode_q, mode_d, tgt_q, tgt_d, req;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    spi_oversample_rx u_rx (
        .clk_i         (ck_1356meg),
        .rst_n_i       (nrst),
        .spck_i        (spck),
        .mosi_i        (mosi),
        .ncs_i         (ncs),
        .rd_buf_i      (rd_buf_q),
        .miso_o        (miso),
        .frame_valid_o (frame_valid),
        .frame_bad_o   (frame_bad),
        .frame_word_o  (frame_word)
    );

    assign cmd  = frame_word[15:12];
    assign addr = frame_word[11:8];
    assign data = frame_word[7:0];

    always_comb begin
        regs_d   = regs_q;
        rd_buf_d = rd_buf_q;
        err_d    = err_q;
        rd_data  = 8'h00;
        addr_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 4'(i)) begin
                addr_ok = 1'b1;
                rd_data = regs_q[i];
            end
        end
        err_bump = frame_bad | (frame_valid & (cmd == CMD_WRITE_REG) & ~addr_ok);
        if (frame_valid) begin
            case (cmd)
                CMD_SET_CONFREG: regs_d[0] = data;
                CMD_WRITE_REG: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr == 4'(i)) regs_d[i] = data;
                    end
                end
                CMD_READ_REG: rd_buf_d = {CMD_READ_REG, addr, rd_data};
                default: ;
            endcase
        end
        if (err_bump && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    // tgt_q remembers the request the guard interval is counting for, so a
    // new request arriving mid-guard restarts the full quiet period.
    assign req = regs_q[0][7 -: MODE_BITS];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (req != mode_q) begin
                    state_d = ST_QUIET;
                    mode_d  = OFF_CODE;
                    tgt_d   = req;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_QUIET: begin
                if (req != tgt_q) begin
                    tgt_d = req;
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    mode_d  = tgt_q;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == 0) ? CONF_RESET : 8'h00;
            rd_buf_q <= '0;
            err_q    <= 8'h00;
            state_q  <= ST_RUN;
            mode_q   <= OFF_CODE;
            tgt_q    <= OFF_CODE;
            cnt_q    <= '0;
        end else begin
            regs_q   <= regs_d;
            rd_buf_q <= rd_buf_d;
            err_q    <= err_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign conf_word      = regs_q[0];
    assign major_mode     = mode_q;
    assign mode_switching = (state_q == ST_QUIET);
    assign frame_err_cnt  = err_q;

endmodule

// File: tb/tb_hf_conf_ctrl.sv
// Directed bench for hf_conf_ctrl: register decode table, read-back, guard
// interval timing, guard restart and reset mid-switch / mid-frame.
module tb_hf_conf_ctrl;

    localparam int G_LONG = 96;

    logic        clk, nrst, spck, mosi, ncs;
    logic        miso, miso_l;
    logic [7:0]  conf_word, conf_word_l, err_cnt, err_cnt_l;
    logic [31:0] regs_flat, regs_flat_l;
    logic [2:0]  major_mode, major_mode_l;
    logic        mode_switching, mode_switching_l;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        logic [7:0]  conf;
        logic [31:0] flat;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[8];

    hf_conf_ctrl u_dut (
        .ck_1356meg     (clk),
        .nrst           (nrst),
        .spck           (spck),
        .mosi           (mosi),
        .ncs            (ncs),
        .miso           (miso),
        .conf_word      (conf_word),
        .regs_flat      (regs_flat),
        .major_mode     (major_mode),
        .mode_switching (mode_switching),
        .frame_err_cnt  (err_cnt)
    );

    hf_conf_ctrl #(.GUARD_CYCLES(G_LONG)) u_dut_long (
        .ck_1356meg     (clk),
        .nrst           (nrst),
        .spck           (spck),
        .mosi           (mosi),
        .ncs            (ncs),
        .miso           (miso_l),
        .conf_word      (conf_word_l),
        .regs_flat      (regs_flat_l),
        .major_mode     (major_mode_l),
        .mode_switching (mode_switching_l),
        .frame_err_cnt  (err_cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drive_bits(input logic [31:0] w, input int nbits, input int hp,
                              output logic [15:0] rx);
        rx = 16'h0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = w[i];
            repeat (hp) @(negedge clk);
            rx = {rx[14:0], miso};
            spck = 1'b1;
            repeat (hp) @(negedge clk);
            spck = 1'b0;
        end
    endtask

    task automatic end_frame(input int hp);
        repeat (hp) @(negedge clk);
        ncs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input int hp,
                              output logic [15:0] rx);
        start_frame();
        drive_bits(w, nbits, hp, rx);
        end_frame(hp);
    endtask

    task automatic check_read(input string name, input logic [31:0] w);
        logic [15:0] rx;
        send_frame(w, 16, 6, rx);
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            check(name, rx, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [15:0] rx;
        int k, n, c, m;
        logic [2:0] mval;

        vecs[0] = '{32'h22A5,  16, 8'h20, 32'h00A5_0020, 8'd0};
        vecs[1] = '{32'h0102,  12, 8'h20, 32'h00A5_0020, 8'd1};
        vecs[2] = '{32'h2511,  16, 8'h20, 32'h00A5_0020, 8'd2};
        vecs[3] = '{32'h23C3,  16, 8'h20, 32'hC3A5_0020, 8'd2};
        vecs[4] = '{32'h4ABC,  16, 8'h20, 32'hC3A5_0020, 8'd2};
        vecs[5] = '{32'h2033,  16, 8'h33, 32'hC3A5_0033, 8'd2};
        vecs[6] = '{32'h12345, 20, 8'h33, 32'hC3A5_0033, 8'd3};
        vecs[7] = '{32'h1120,  16, 8'h20, 32'hC3A5_0020, 8'd3};

        // clock / reset
        nrst = 1'b0; spck = 1'b0; mosi = 1'b0; ncs = 1'b1;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_conf", conf_word, 8'hE0);
        check("rst_flat", regs_flat, 32'h0000_00E0);
        check("rst_mode", major_mode, 3'd7);
        check("rst_switching", mode_switching, 1'b0);
        check("rst_err", err_cnt, 8'd0);
        check("rst_miso", miso, 1'b0);

        // first mode switch with exact guard length
        start_frame();
        drive_bits(32'h1020, 16, 2, rx);
        repeat (2) @(negedge clk);
        ncs = 1'b1;
        k = 0;
        while (k < 8 && conf_word !== 8'h20) begin
            @(negedge clk);
            k++;
        end
        check("conf_within_3", (k <= 3), 1'b1);
        check("conf_0x20", conf_word, 8'h20);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (mode_switching === 1'b1 && major_mode === 3'd7) n++;
            else break;
        end
        check("guard_len", n, 16);
        check("mode_after_guard", major_mode, 3'd1);
        check("switching_after_guard", mode_switching, 1'b0);

        // table-driven register decode
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].frame, vecs[i].nbits, 2, rx);
            check($sformatf("vec%0d_conf", i), conf_word, vecs[i].conf);
            check($sformatf("vec%0d_flat", i), regs_flat, vecs[i].flat);
            check($sformatf("vec%0d_err", i), err_cnt, vecs[i].err);
        end

        // read-back on miso during the following frame
        send_frame(32'h3200, 16, 2, rx);
        exp_q.push_back(16'h32A5);
        check_read("read_reg2", 32'h3300);
        exp_q.push_back(16'h33C3);
        check_read("read_reg3", 32'h0000);
        exp_q.push_back(16'h33C3);
        check_read("read_hold", 32'h0000);
        send_frame(32'h00, 8, 2, rx);
        check("miso_idle", miso, 1'b0);
        check("err_short", err_cnt, 8'd4);
        send_frame(32'h3900, 16, 2, rx);
        exp_q.push_back(16'h3900);
        check_read("read_oob", 32'h0000);

        // guard restart on the long-guard instance
        send_frame(32'h10E0, 16, 2, rx);
        repeat (150) @(negedge clk);
        check("long_off_settled", major_mode_l, 3'd7);
        start_frame();
        drive_bits(32'h1020, 16, 2, rx);
        end_frame(2);
        check("long_in_quiet", mode_switching_l, 1'b1);
        c = -1; m = -1; mval = 3'd0;
        fork
            send_frame(32'h1040, 16, 2, rx);
            begin
                for (int i = 1; i <= 400 && m < 0; i++) begin
                    @(negedge clk);
                    if (c < 0 && conf_word_l === 8'h40) c = i;
                    if (major_mode_l !== 3'd7) begin
                        m = i;
                        mval = major_mode_l;
                    end
                end
            end
        join
        check("restart_off_len", m - c - 1, G_LONG);
        check("restart_mode", mval, 3'd2);
        check("restart_switching", mode_switching_l, 1'b0);

        // reset in the middle of a guard interval
        send_frame(32'h1020, 16, 2, rx);
        check("pre_reset_quiet", mode_switching, 1'b1);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("rstq_conf", conf_word, 8'hE0);
        check("rstq_mode", major_mode, 3'd7);
        check("rstq_switching", mode_switching, 1'b0);
        check("rstq_err", err_cnt, 8'd0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // reset in the middle of a frame: the tail must be discarded silently
        start_frame();
        drive_bits(32'h10, 8, 2, rx);
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        drive_bits(32'h60, 8, 2, rx);
        end_frame(2);
        check("rstf_conf", conf_word, 8'hE0);
        check("rstf_flat", regs_flat, 32'h0000_00E0);
        check("rstf_err", err_cnt, 8'd0);
        check("rstf_mode", major_mode, 3'd7);
        check("rstf_switching", mode_switching, 1'b0);
        send_frame(32'h2133, 16, 2, rx);
        check("post_reset_write", regs_flat, 32'h0000_33E0);
        check("post_reset_err", err_cnt, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
